// File: rtl/serial_subtractor_2bit_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// serial_subtractor_2bit_if
//
// Purpose:
//   Groups the start/done handshake and the operand/result buses of the
//   2-bit-per-cycle serial subtractor. Clock and reset stay plain ports on
//   the subtractor itself.
//
// Signals:
//   start   host -> subtractor  request, honoured only while ready=1
//   a, b    host -> subtractor  minuend / subtrahend, captured on accept
//   ready   subtractor -> host  idle, a start will be accepted
//   busy    subtractor -> host  slices are being processed
//   done    subtractor -> host  one-cycle pulse, results valid
//   diff    subtractor -> host  (a - b) mod 2^WIDTH
//   borrow  subtractor -> host  a < b (unsigned)
//   ovf     subtractor -> host  signed overflow of a - b
//
// Modports:
//   master  the host side (drives start/a/b)
//   slave   the subtractor side (drives status and results)
// ---------------------------------------------------------------------------
interface serial_subtractor_2bit_if #(
    parameter int WIDTH = 8
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;

    modport master (
        output start,
        output a,
        output b,
        input  ready,
        input  busy,
        input  done,
        input  diff,
        input  borrow,
        input  ovf
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output ready,
        output busy,
        output done,
        output diff,
        output borrow,
        output ovf
    );

endinterface

// File: rtl/serial_subtractor_2bit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// serial_subtractor_2bit
//
// Purpose:
//   Multi-cycle subtractor computing a - b two bits per clock, least
//   significant slice first, with a registered borrow rippling from one
//   slice to the next. A start/done handshake lets a host issue one
//   subtraction at a time. Results are valid for both unsigned (borrow)
//   and two's-complement (ovf) interpretations.
//
// Parameters:
//   WIDTH   operand width, even and >= 2; processed in WIDTH/2 slices
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset; abandons any operation in flight
//   bus     serial_subtractor_2bit_if.slave
//             start/a/b in, ready/busy/done/diff/borrow/ovf out
//
// Timing (accept at edge E0):
//   slices processed at E1..E(WIDTH/2), done high for the cycle after
//   E(WIDTH/2), ready again after E(WIDTH/2+1).
// ---------------------------------------------------------------------------
module serial_subtractor_2bit #(
    parameter int WIDTH = 8
) (
    input logic                     clk,
    input logic                     rst_n,
    serial_subtractor_2bit_if.slave bus
);

    localparam int SLICES = WIDTH / 2;
    localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(SLICES - 1);

    // State encoding kept as plain constants so older tooling can read it.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // -----------------------------------------------------------------------
    // One 2-bit slice of a subtraction: {bout, d} = x - y - bin.
    // The 3-bit result of the zero-extended subtraction lies in -4..3, so
    // its top bit is exactly the borrow out of the slice.
    // -----------------------------------------------------------------------
    function automatic logic [2:0] sub_slice(
        input logic [1:0] x,
        input logic [1:0] y,
        input logic       bin
    );
        logic [2:0] t;
        t = {1'b0, x} - {1'b0, y} - {2'b00, bin};
        return t;
    endfunction

    // -----------------------------------------------------------------------
    // Signed overflow of a - b: only possible when the operand signs differ,
    // and then flagged when the result sign disagrees with the minuend.
    // -----------------------------------------------------------------------
    function automatic logic sub_ovf(
        input logic a_msb,
        input logic b_msb,
        input logic r_msb
    );
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_q;
    logic [WIDTH-1:0] diff_nxt;
    logic             bin_q;
    logic             borrow_q;
    logic             ovf_q;

    logic [1:0]       a_sl;
    logic [1:0]       b_sl;
    logic [1:0]       d_sl;
    logic             bout;
    logic             accept;
    logic             last_sl;

    assign accept  = (state == S_IDLE) && bus.start;
    assign last_sl = (cnt == LAST_SLICE);

    // -----------------------------------------------------------------------
    // Slice select: pick the operand bits addressed by the counter.
    // -----------------------------------------------------------------------
    always_comb begin
        a_sl = 2'b00;
        b_sl = 2'b00;
        for (int k = 0; k < SLICES; k++) begin
            if (cnt == CNT_W'(k)) begin
                a_sl = a_q[2*k +: 2];
                b_sl = b_q[2*k +: 2];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Slice arithmetic and result merge into the partially built difference.
    // -----------------------------------------------------------------------
    always_comb begin
        {bout, d_sl} = sub_slice(a_sl, b_sl, bin_q);
        diff_nxt     = diff_q;
        for (int k = 0; k < SLICES; k++) begin
            if (cnt == CNT_W'(k)) begin
                diff_nxt[2*k +: 2] = d_sl;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM next state.
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_RUN;
            S_RUN:   if (last_sl)   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Operand capture, slice counter, ripple borrow and results.
    // Results are cleared on accept and then hold from DONE until the next
    // accept, so the host may read them any time ready is high.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            bin_q    <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            cnt      <= '0;
            a_q      <= bus.a;
            b_q      <= bus.b;
            diff_q   <= '0;
            bin_q    <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (state == S_RUN) begin
            cnt    <= cnt + 1'b1;
            diff_q <= diff_nxt;
            bin_q  <= bout;
            if (last_sl) begin
                borrow_q <= bout;
                // d_sl[1] is the MSB of the final result on the last slice.
                ovf_q    <= sub_ovf(a_q[WIDTH-1], b_q[WIDTH-1], d_sl[1]);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs.
    // -----------------------------------------------------------------------
    assign bus.ready  = (state == S_IDLE);
    assign bus.busy   = (state == S_RUN);
    assign bus.done   = (state == S_DONE);
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
    assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor_2bit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_serial_subtractor_2bit
//
// Purpose:
//   Self-checking bench for serial_subtractor_2bit (WIDTH=8). Expected
//   results come from a plain-arithmetic reference of a - b; handshake
//   timing, held-start behaviour and asynchronous reset are checked too.
// ---------------------------------------------------------------------------
module tb_serial_subtractor_2bit;

    localparam int W = 8;
    localparam int HALF = W / 2;

    logic clk;
    logic rst_n;

    int n_cmp;
    int n_err;

    serial_subtractor_2bit_if #(.WIDTH(W)) bus ();

    serial_subtractor_2bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: ordinary integer arithmetic on the operand values.
    task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         output logic [W-1:0] ed, output logic eb, output logic eo);
        int ua, ub, sa, sb, sd;
        ua = int'(ta);
        ub = int'(tb);
        sa = (ua >= 2**(W-1)) ? ua - 2**W : ua;
        sb = (ub >= 2**(W-1)) ? ub - 2**W : ub;
        sd = sa - sb;
        ed = W'((ua - ub + 2**W) % (2**W));
        eb = (ua < ub);
        eo = (sd > 2**(W-1) - 1) || (sd < -(2**(W-1)));
    endtask

    // One full operation; operands are scrambled after accept to show they
    // are held internally.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input string tag);
        int cyc;
        logic [W-1:0] ed;
        logic eb, eo;
        model(ta, tb, ed, eb, eo);
        cyc = 0;
        while (bus.ready !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_ready"}, 32'(bus.ready), 32'd1);
        bus.start = 1'b1;
        bus.a = ta;
        bus.b = tb;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 20) begin
            if (bus.ready === 1'b1 && bus.busy === 1'b1)
                chk({tag, "_rdy_busy"}, 32'd1, 32'd0);
            @(negedge clk);
            bus.a = W'($urandom);
            bus.b = W'($urandom);
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(HALF));
        chk({tag, "_diff"}, 32'(bus.diff), 32'(ed));
        chk({tag, "_borrow"}, 32'(bus.borrow), 32'(eb));
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
        chk({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk({tag, "_done_1cyc"}, 32'(bus.done), 32'd0);
        chk({tag, "_ready_back"}, 32'(bus.ready), 32'd1);
        chk({tag, "_diff_hold"}, 32'(bus.diff), 32'(ed));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        int cyc;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_diff", 32'(bus.diff), 32'd0);
        chk("rst_borrow", 32'(bus.borrow), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        rst_n = 1'b1;

        // Directed cases
        run_op(8'd200, 8'd55, "d200_55");
        run_op(8'd55, 8'd200, "d55_200");
        run_op(8'h80, 8'h01, "d80_01");
        run_op(8'h00, 8'h00, "d00_00");
        run_op(8'h00, 8'h01, "d00_01");
        run_op(8'h7F, 8'hFF, "d7f_ff");
        run_op(8'hFF, 8'hFF, "dff_ff");

        // Held start: only one done for the first op, then re-accept
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 8'd10;
        bus.b = 8'd3;
        @(posedge clk);
        @(negedge clk);
        bus.a = 8'd99;
        bus.b = 8'd1;
        ndone = 0;
        for (int i = 1; i <= HALF + 1; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                ndone++;
                chk("hold_diff", 32'(bus.diff), 32'd7);
            end
        end
        chk("hold_ndone", 32'(ndone), 32'd1);
        chk("hold_ready_e5", 32'(bus.ready), 32'd1);
        @(negedge clk);
        chk("hold_reaccept", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("hold2_latency", 32'(cyc), 32'(HALF));
        chk("hold2_diff", 32'(bus.diff), 32'd98);
        chk("hold2_borrow", 32'(bus.borrow), 32'd0);

        // Asynchronous reset mid-operation
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 8'hFF;
        bus.b = 8'h00;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_diff", 32'(bus.diff), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_ready", 32'(bus.ready), 32'd1);
        chk("arst_done", 32'(bus.done), 32'd0);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            if (bus.done === 1'b1) ndone++;
        end
        chk("arst_no_done", 32'(ndone), 32'd0);
        run_op(8'd9, 8'd4, "post_rst");

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
